accum_buf: RTL and testbench

ACCUM_BUF -- requirements
Module: accum_buf

---
 rtl/accum_buf.sv | 171 +++++++++++++++++
 tb/tb_accum_buf.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_buf.sv
// Per-column accumulator banks fed by a systolic array, drained one row (all banks, same address) at a time.
// Optional: define ACCUM_SAT_EN to saturate accumulate-mode additions instead of wrapping.
module accum_buf #(
  parameter int SYS_COL    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_SIZE = 1024,
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH,
  localparam int ADDR_WIDTH = $clog2(ACCUM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  acc_mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] num_row,
  input  logic [PSUM_WIDTH-1:0] psum_in [0:SYS_COL-1],
  input  logic [SYS_COL-1:0]    psum_valid,
  input  logic                  rd_start,
  input  logic                  out_ready,
  output logic [PSUM_WIDTH-1:0] out_data [0:SYS_COL-1],
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  acc_done,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t state_q, state_d;

  logic signed [PSUM_WIDTH-1:0] mem [SYS_COL][ACCUM_SIZE];

  logic [DATA_WIDTH-1:0] cnt     [SYS_COL];
  logic [DATA_WIDTH-1:0] cnt_nxt [SYS_COL];
  logic [ADDR_WIDTH-1:0] wr_addr [SYS_COL];
  logic [SYS_COL-1:0]    wr_en;
  logic                  all_done;
  logic                  acc_done_d;
  logic                  err_set;
  logic                  acc_mode_q;
  logic [DATA_WIDTH-1:0] num_row_q;
  logic [DATA_WIDTH-1:0] num_row_eff;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_left;

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(ACCUM_SIZE - 1)) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

  function automatic logic signed [PSUM_WIDTH-1:0] acc_add(
    input logic signed [PSUM_WIDTH-1:0] a,
    input logic signed [PSUM_WIDTH-1:0] b
  );
`ifdef ACCUM_SAT_EN
    logic signed [PSUM_WIDTH:0] sum;
    sum = {a[PSUM_WIDTH-1], a} + {b[PSUM_WIDTH-1], b};
    if (sum[PSUM_WIDTH] != sum[PSUM_WIDTH-1])
      return sum[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}} : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    return sum[PSUM_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  assign num_row_eff = (num_row == '0) ? DATA_WIDTH'(1) : num_row;
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    acc_done_d = 1'b0;
    wr_en      = '0;
    err_set    = 1'b0;
    all_done   = 1'b1;
    for (int c = 0; c < SYS_COL; c++) begin
      cnt_nxt[c] = cnt[c];
      if (psum_valid[c]) begin
        if (state_q == ACCUM && cnt[c] < num_row_q) begin
          wr_en[c]   = 1'b1;
          cnt_nxt[c] = cnt[c] + DATA_WIDTH'(1);
        end else begin
          err_set = 1'b1;
        end
      end
      if (cnt_nxt[c] != num_row_q) all_done = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (start)         state_d = ACCUM;
        else if (rd_start) state_d = DRAIN;
      end
      ACCUM: begin
        if (all_done) begin
          state_d    = IDLE;
          acc_done_d = 1'b1;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bank write: read-modify-write of the addressed entry, contents never reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < SYS_COL; c++) begin
      if (wr_en[c])
        mem[c][wr_addr[c]] <= acc_mode_q ? acc_add(mem[c][wr_addr[c]], psum_in[c]) : psum_in[c];
    end
  end

  // Control and registered drain output stage
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      acc_done  <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int c = 0; c < SYS_COL; c++) begin
        cnt[c]      <= '0;
        out_data[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      acc_done <= acc_done_d;
      if (err_set) err <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_mode_q <= acc_mode;
            num_row_q  <= num_row_eff;
            for (int c = 0; c < SYS_COL; c++) begin
              cnt[c]     <= '0;
              wr_addr[c] <= base_addr;
            end
          end else if (rd_start) begin
            for (int c = 0; c < SYS_COL; c++) out_data[c] <= mem[c][base_addr];
            out_valid <= 1'b1;
            out_last  <= (num_row_eff == DATA_WIDTH'(1));
            rd_addr   <= addr_inc(base_addr);
            rd_left   <= num_row_eff - DATA_WIDTH'(1);
          end
        end
        ACCUM: begin
          for (int c = 0; c < SYS_COL; c++) begin
            cnt[c] <= all_done ? '0 : cnt_nxt[c];
            if (wr_en[c]) wr_addr[c] <= addr_inc(wr_addr[c]);
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              for (int c = 0; c < SYS_COL; c++) out_data[c] <= mem[c][rd_addr];
              out_last <= (rd_left == DATA_WIDTH'(1));
              rd_addr  <= addr_inc(rd_addr);
              rd_left  <= rd_left - DATA_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_buf.sv
// Directed bench for accum_buf: a memory/queue reference model plus one per-cycle output compare process.
module tb_accum_buf;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        acc_mode;
  logic [9:0]  base_addr;
  logic [15:0] num_row;
  logic [31:0] psum_in [0:3];
  logic [3:0]  psum_valid;
  logic        rd_start;
  logic        out_ready;
  logic [31:0] out_data [0:3];
  logic        out_valid;
  logic        out_last;
  logic        acc_done;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  mref [4][1024];
  logic [31:0]  pv   [4][8];
  logic [127:0] exp_q [$];
  logic [31:0]  cap_q [$];
  logic         hold_chk = 1'b0;

  always #5 clk = ~clk;

  accum_buf dut (
    .clk(clk), .rstn(rstn), .start(start), .acc_mode(acc_mode), .base_addr(base_addr),
    .num_row(num_row), .psum_in(psum_in), .psum_valid(psum_valid), .rd_start(rd_start),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .acc_done(acc_done), .busy(busy), .err(err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] add_m(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef ACCUM_SAT_EN
    if (s > 64'sh7FFF_FFFF)  return 32'h7FFF_FFFF;
    if (s < -64'sh8000_0000) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every valid output row must equal the head of the expected queue
  always @(negedge clk) begin
    if (!rstn) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk && !out_valid) chk("out_valid_hold", {63'd0, out_valid}, 64'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          for (int c = 0; c < 4; c++)
            chk($sformatf("out_data_c%0d", c), {32'd0, out_data[c]}, {32'd0, exp_q[0][32*c +: 32]});
          chk("out_last", {63'd0, out_last}, {63'd0, exp_q.size() == 1});
          if (out_ready) begin
            for (int c = 0; c < 4; c++) cap_q.push_back(out_data[c]);
            void'(exp_q.pop_front());
          end
        end
      end
      hold_chk = out_valid && !out_ready;
    end
  end

  task automatic run_pass(input int base, input int nrow, input logic mode,
                          input logic with_rd, input logic extra);
    int a;
    start = 1'b1; rd_start = with_rd; acc_mode = mode;
    base_addr = 10'(base); num_row = 16'(nrow);
    tick();
    start = 1'b0; rd_start = 1'b0;
    chk("pass_busy", {63'd0, busy}, 64'd1);
    for (int t = 0; t < nrow + 3; t++) begin
      start    = (t == 1);
      rd_start = (t == 1);
      for (int c = 0; c < 4; c++) begin
        psum_valid[c] = (t - c >= 0) && (t - c < nrow);
        if (psum_valid[c]) begin
          psum_in[c] = pv[c][t-c];
          a = (base + t - c) % 1024;
          mref[c][a] = mode ? add_m(mref[c][a], pv[c][t-c]) : pv[c][t-c];
        end
      end
      if (extra && t == nrow) begin
        psum_valid[0] = 1'b1;
        psum_in[0]    = 32'd999;
      end
      if (t == nrow + 2) chk("acc_done_early", {63'd0, acc_done}, 64'd0);
      tick();
    end
    psum_valid = '0; start = 1'b0; rd_start = 1'b0;
    chk("acc_done_pulse", {63'd0, acc_done}, 64'd1);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    tick();
    chk("acc_done_one_cycle", {63'd0, acc_done}, 64'd0);
  endtask

  task automatic run_drain(input int base, input int nrow, input logic [3:0] pat);
    int a;
    int k;
    for (int r = 0; r < nrow; r++) begin
      a = (base + r) % 1024;
      exp_q.push_back({mref[3][a], mref[2][a], mref[1][a], mref[0][a]});
    end
    cap_q.delete();
    rd_start = 1'b1; base_addr = 10'(base); num_row = 16'(nrow); out_ready = 1'b0;
    tick();
    rd_start = 1'b0;
    chk("drain_first_valid", {63'd0, out_valid}, 64'd1);
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      out_ready = pat[k % 4];
      k++;
      tick();
    end
    out_ready = 1'b0;
    if (k >= 200) chk("drain_timeout", 64'(k), 64'd0);
    if (pat == 4'hF) chk("drain_no_bubble", 64'(k), 64'(nrow));
    chk("drain_count", 64'(cap_q.size()), 64'(nrow * 4));
    chk("drain_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("drain_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] sat_exp;
    logic [31:0] first_r4;
    rstn = 1'b0; start = 1'b0; acc_mode = 1'b0; base_addr = '0; num_row = '0;
    psum_valid = '0; rd_start = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) psum_in[c] = '0;
    tick(); tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_acc_done", {63'd0, acc_done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_out_data0", {32'd0, out_data[0]}, 64'd0);
    rstn = 1'b1;
    tick();

    // Overwrite pass with skewed columns, start and rd_start together
    for (int c = 0; c < 4; c++) for (int r = 0; r < 8; r++) pv[c][r] = 32'(10 * c + r);
    run_pass(0, 4, 1'b0, 1'b1, 1'b0);
    chk("err_clean_pass", {63'd0, err}, 64'd0);
    run_drain(0, 4, 4'hF);
    chk("lit_r0c0", {32'd0, cap_q[0]}, 64'd0);
    chk("lit_r1c2", {32'd0, cap_q[6]}, 64'd21);
    chk("lit_r3c3", {32'd0, cap_q[15]}, 64'd33);

    // Accumulate pass doubles, drained with a stalling consumer
    run_pass(0, 4, 1'b1, 1'b0, 1'b0);
    run_drain(0, 4, 4'b1001);
    chk("lit_dbl_r2c3", {32'd0, cap_q[11]}, 64'd64);

    // Address wrap
    for (int c = 0; c < 4; c++) for (int r = 0; r < 8; r++) pv[c][r] = 32'(1000 * c + r + 5);
    run_pass(1023, 2, 1'b0, 1'b0, 1'b0);
    run_drain(1023, 2, 4'hF);
    chk("lit_wrap_1023c0", {32'd0, cap_q[0]}, 64'd5);
    chk("lit_wrap_0c1", {32'd0, cap_q[5]}, 64'd1006);

    // Extra psum on a completed column: ignored, err sticky
    for (int c = 0; c < 4; c++) for (int r = 0; r < 8; r++) pv[c][r] = 32'(200 + 3 * r + c);
    run_pass(100, 5, 1'b0, 1'b0, 1'b0);
    first_r4 = pv[0][4];
    chk("err_before_extra", {63'd0, err}, 64'd0);
    for (int c = 0; c < 4; c++) for (int r = 0; r < 8; r++) pv[c][r] = 32'(300 + 5 * r + c);
    run_pass(100, 4, 1'b0, 1'b0, 1'b1);
    chk("err_extra_psum", {63'd0, err}, 64'd1);
    run_drain(100, 5, 4'hF);
    chk("lit_no_extra_write", {32'd0, cap_q[16]}, {32'd0, first_r4});
    chk("err_sticky", {63'd0, err}, 64'd1);

    // psum in IDLE flags err; reset mid-ACCUM clears state
    rstn = 1'b0; tick(); rstn = 1'b1;
    chk("err_cleared", {63'd0, err}, 64'd0);
    psum_valid = 4'b0010; tick(); psum_valid = '0;
    chk("err_idle_psum", {63'd0, err}, 64'd1);
    start = 1'b1; acc_mode = 1'b0; base_addr = 10'd200; num_row = 16'd4;
    tick();
    start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      psum_valid = 4'b0001; psum_in[0] = 32'(77 + t);
      mref[0][200 + t] = 32'(77 + t);
      tick();
    end
    psum_valid = '0;
    rstn = 1'b0; tick(); rstn = 1'b1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_err", {63'd0, err}, 64'd0);
    chk("midrst_acc_done", {63'd0, acc_done}, 64'd0);
    tick();
    for (int c = 0; c < 4; c++) for (int r = 0; r < 8; r++) pv[c][r] = 32'(40 + r + c);
    run_pass(200, 4, 1'b0, 1'b0, 1'b0);
    run_drain(200, 4, 4'hF);

    // Accumulate overflow near signed max
    for (int c = 0; c < 4; c++) pv[c][0] = 32'(c);
    pv[0][0] = 32'h7FFF_FFF0;
    run_pass(50, 1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) pv[c][0] = 32'hFFFF_FFFF;
    pv[0][0] = 32'h0000_0020;
    run_pass(50, 1, 1'b1, 1'b0, 1'b0);
    run_drain(50, 1, 4'hF);
`ifdef ACCUM_SAT_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h8000_0010;
`endif
    chk("lit_overflow_c0", {32'd0, cap_q[0]}, {32'd0, sat_exp});
    chk("lit_minus_one_c2", {32'd0, cap_q[2]}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
